// File: rtl/mac_io_sequencer.sv
// Pin-level serial sequencer for the 8x8 MAC datapath: shifts operands in, launches the MAC, drains the result.
// Define MACSEQ_PARITY_EN to append an even-parity bit after the carry in the output frame.
module mac_io_sequencer #(
    parameter int OP_W    = 8,
    parameter int RES_W   = 20,
    parameter int TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_i,
    input  logic             ser_a_i,
    input  logic             ser_b_i,
    output logic [OP_W-1:0]  mac_a_o,
    output logic [OP_W-1:0]  mac_b_o,
    output logic             mac_load_o,
    output logic             mac_begin_o,
    input  logic             mac_done_i,
    input  logic [RES_W-1:0] mac_res_i,
    input  logic             mac_carry_i,
    output logic             ser_out_o,
    output logic             ser_valid_o,
    output logic             busy_o,
    output logic             finish_o,
    output logic             err_o
);

`ifdef MACSEQ_PARITY_EN
    localparam int FRAME = RES_W + 2;
`else
    localparam int FRAME = RES_W + 1;
`endif
    localparam int CW = $clog2(RES_W + 2);
    localparam int TW = $clog2(TIMEOUT);
    localparam int SW = OP_W - 1;
    localparam logic [CW-1:0] SHIFT_LAST = CW'(OP_W - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(FRAME - 1);
    // Abort on the edge where the counter would step onto TIMEOUT-1.
    localparam logic [TW-1:0] RUN_LAST   = TW'(TIMEOUT - 2);

    typedef enum logic [2:0] {IDLE, SHIFT, LOAD, LAUNCH, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic             start_q;
    logic             start_edge;
    logic [SW-1:0]    sh_a, sh_b;
    logic [FRAME-2:0] out_sh;
    logic [FRAME-1:0] frame_in;
    logic [CW-1:0]    bit_cnt;
    logic [TW-1:0]    run_cnt;

    assign start_edge = start_i & ~start_q;

    always_comb begin
`ifdef MACSEQ_PARITY_EN
        frame_in = {^{mac_carry_i, mac_res_i}, mac_carry_i, mac_res_i};
`else
        frame_in = {mac_carry_i, mac_res_i};
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            start_q     <= 1'b0;
            sh_a        <= '0;
            sh_b        <= '0;
            out_sh      <= '0;
            bit_cnt     <= '0;
            run_cnt     <= '0;
            mac_a_o     <= '0;
            mac_b_o     <= '0;
            mac_load_o  <= 1'b0;
            mac_begin_o <= 1'b0;
            ser_out_o   <= 1'b0;
            ser_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            finish_o    <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            start_q     <= start_i;
            mac_load_o  <= 1'b0;
            mac_begin_o <= 1'b0;
            finish_o    <= 1'b0;
            err_o       <= 1'b0;
            case (state)
                IDLE: if (start_edge) begin
                    state   <= SHIFT;
                    busy_o  <= 1'b1;
                    bit_cnt <= '0;
                end
                SHIFT: begin
                    sh_a    <= SW'({sh_a, ser_a_i});
                    sh_b    <= SW'({sh_b, ser_b_i});
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == SHIFT_LAST) begin
                        // The final bit goes straight to the operand register.
                        state      <= LOAD;
                        bit_cnt    <= '0;
                        mac_a_o    <= {sh_a, ser_a_i};
                        mac_b_o    <= {sh_b, ser_b_i};
                        mac_load_o <= 1'b1;
                    end
                end
                LOAD: begin
                    state       <= LAUNCH;
                    bit_cnt     <= '0;
                    mac_begin_o <= 1'b1;
                end
                LAUNCH: begin
                    state   <= RUN;
                    bit_cnt <= '0;
                    run_cnt <= '0;
                end
                RUN: begin
                    if (mac_done_i) begin
                        state       <= DRAIN;
                        bit_cnt     <= '0;
                        out_sh      <= frame_in[FRAME-1:1];
                        ser_out_o   <= frame_in[0];
                        ser_valid_o <= 1'b1;
                    end else if (run_cnt == RUN_LAST) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        busy_o  <= 1'b0;
                        err_o   <= 1'b1;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (bit_cnt == DRAIN_LAST) begin
                        state       <= DONE;
                        bit_cnt     <= '0;
                        ser_out_o   <= 1'b0;
                        ser_valid_o <= 1'b0;
                        finish_o    <= 1'b1;
                    end else begin
                        bit_cnt   <= bit_cnt + 1'b1;
                        ser_out_o <= out_sh[0];
                        out_sh    <= out_sh >> 1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                    busy_o  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_io_sequencer.sv
// Directed bench for mac_io_sequencer: table of full frames plus timeout, reset and START-edge sequences.
module tb_mac_io_sequencer;

`ifdef MACSEQ_PARITY_EN
    localparam int          FRAME = 22;
    localparam logic [21:0] FMASK = 22'h3FFFFF;
`else
    localparam int          FRAME = 21;
    localparam logic [21:0] FMASK = 22'h1FFFFF;
`endif

    logic        clock, reset, start_i, ser_a_i, ser_b_i;
    logic [7:0]  mac_a_o, mac_b_o;
    logic        mac_load_o, mac_begin_o, mac_done_i, mac_carry_i;
    logic [19:0] mac_res_i;
    logic        ser_out_o, ser_valid_o, busy_o, finish_o, err_o;
    logic [22:0] outs;

    mac_io_sequencer #(.OP_W(8), .RES_W(20), .TIMEOUT(64)) dut (
        .clock(clock), .reset(reset), .start_i(start_i),
        .ser_a_i(ser_a_i), .ser_b_i(ser_b_i),
        .mac_a_o(mac_a_o), .mac_b_o(mac_b_o),
        .mac_load_o(mac_load_o), .mac_begin_o(mac_begin_o),
        .mac_done_i(mac_done_i), .mac_res_i(mac_res_i), .mac_carry_i(mac_carry_i),
        .ser_out_o(ser_out_o), .ser_valid_o(ser_valid_o), .busy_o(busy_o),
        .finish_o(finish_o), .err_o(err_o)
    );

    assign outs = {mac_a_o, mac_b_o, mac_load_o, mac_begin_o, ser_out_o,
                   ser_valid_o, busy_o, finish_o, err_o};

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [19:0] res;
        logic        carry;
        int          delay;   // RUN cycle index carrying done; <0 never done
        logic [21:0] exp;     // {parity, carry, res}, sent LSB first
    } vec_t;

    vec_t vecs[4];
    int   n_vec = 0, n_miss = 0;
    int   fin_cnt = 0, err_cnt = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (finish_o) fin_cnt <= fin_cnt + 1;
        if (err_o)    err_cnt <= err_cnt + 1;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called in an IDLE cycle with start_i low in the previous cycle; returns in an IDLE cycle.
    task automatic run_txn(input vec_t v, input bit toggle, input bit keep, input int rst_bit);
        logic [21:0] got;
        int bad, cyc, fin0, err0;
        got = '0; bad = 0; fin0 = fin_cnt; err0 = err_cnt;
        start_i = 1'b1;
        step();
        chk("busy_shift", 32'(busy_o), 1);
        if (!keep) start_i = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            ser_a_i = v.a[k];
            ser_b_i = v.b[k];
            if (toggle && k == 5) start_i = 1'b0;
            if (toggle && k == 4) start_i = 1'b1;
            step();
        end
        chk("load_strobe", 32'({mac_load_o, mac_begin_o}), 2);
        chk("load_a", 32'(mac_a_o), 32'(v.a));
        chk("load_b", 32'(mac_b_o), 32'(v.b));
        step();
        chk("launch_strobe", 32'({mac_load_o, mac_begin_o}), 1);
        if (v.delay < 0) begin
            cyc = 0;
            while (!err_o && cyc < 100) begin
                step();
                cyc++;
            end
            chk("timeout_cycles", 32'(cyc), 64);
            chk("timeout_busy", 32'(busy_o), 0);
            step();
            chk("err_single_pulse", 32'(err_o), 0);
            chk("timeout_no_finish", 32'(fin_cnt - fin0), 0);
            return;
        end
        step();
        for (int c = 0; c < v.delay; c++) step();
        mac_done_i = 1'b1; mac_res_i = v.res; mac_carry_i = v.carry;
        step();
        mac_done_i = 1'b0; mac_res_i = ~v.res; mac_carry_i = ~v.carry;
        for (int i = 0; i < FRAME; i++) begin
            if (ser_valid_o !== 1'b1) bad++;
            got[i] = ser_out_o;
            if (i == rst_bit) begin
                #2 reset = 1'b1;
                #1;
                chk("async_reset_outs", 32'(outs), 0);
                step();
                step();
                reset = 1'b0;
                start_i = 1'b0;
                step();
                chk("reset_no_pulse", 32'((fin_cnt - fin0) + (err_cnt - err0)), 0);
                return;
            end
            step();
        end
        chk("drain_valid", 32'(bad), 0);
        chk("frame", 32'(got & FMASK), 32'(v.exp & FMASK));
        chk("done_cycle", 32'({finish_o, ser_valid_o, ser_out_o}), 4);
        step();
        chk("idle_busy", 32'(busy_o), 0);
        chk("finish_once", 32'(fin_cnt - fin0), 1);
        chk("no_err", 32'(err_cnt - err0), 0);
    endtask

    initial begin
        #200000;
        n_miss++;
        $display("FAIL watchdog: got timeout expected $finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        vec_t tv;
        int bad;
        vecs[0] = '{a: 8'h03, b: 8'h05, res: 20'h0000F, carry: 1'b0, delay: 9,  exp: 22'h00000F};
        vecs[1] = '{a: 8'hFF, b: 8'hFF, res: 20'h0FE01, carry: 1'b1, delay: 3,  exp: 22'h30FE01};
        vecs[2] = '{a: 8'hA5, b: 8'h3C, res: 20'hABCDE, carry: 1'b0, delay: 0,  exp: 22'h2ABCDE};
        // done on the last RUN cycle, the same one that would otherwise time out
        vecs[3] = '{a: 8'h80, b: 8'h01, res: 20'hFFFFF, carry: 1'b1, delay: 62, exp: 22'h3FFFFF};

        reset = 1'b1; start_i = 1'b0; ser_a_i = 1'b0; ser_b_i = 1'b0;
        mac_done_i = 1'b0; mac_res_i = '0; mac_carry_i = 1'b0;
        #3;
        chk("reset_outs", 32'(outs), 0);
        step();
        step();
        reset = 1'b0;
        step();

        // back-to-back frames from the table
        for (int i = 0; i < 4; i++) run_txn(vecs[i], 1'b0, 1'b0, -1);

        tv = '{a: 8'h12, b: 8'h34, res: 20'h0, carry: 1'b0, delay: -1, exp: 22'h0};
        run_txn(tv, 1'b0, 1'b0, -1);

        run_txn(vecs[0], 1'b0, 1'b0, 7);
        run_txn(vecs[0], 1'b0, 1'b0, -1);

        // START held high (and toggled in SHIFT) must not retrigger
        run_txn(vecs[1], 1'b1, 1'b1, -1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (busy_o !== 1'b0) bad++;
        end
        chk("no_retrigger", 32'(bad), 0);
        start_i = 1'b0;
        step();
        run_txn(vecs[2], 1'b0, 1'b0, -1);
        run_txn(vecs[0], 1'b0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
